// File: rtl/rf_wport_arbiter_if.sv
// Write-port bundle between the WB stage / aux unit (master side) and the
// register-file write-port arbiter (slave side).
interface rf_wport_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             i_wb_we;
  logic [4:0]       i_wb_rdst;
  logic [WIDTH-1:0] i_wb_data;
  logic             i_aux_valid;
  logic [4:0]       i_aux_rdst;
  logic [WIDTH-1:0] i_aux_data;
  logic             o_aux_ready;
  logic             o_rf_we;
  logic [4:0]       o_rf_rdst;
  logic [WIDTH-1:0] o_rf_data;
  logic             o_stall_req;
  logic             o_grant_aux;

  modport master (
    output i_wb_we, i_wb_rdst, i_wb_data,
    output i_aux_valid, i_aux_rdst, i_aux_data,
    input  o_aux_ready, o_rf_we, o_rf_rdst, o_rf_data, o_stall_req, o_grant_aux
  );

  modport slave (
    input  i_wb_we, i_wb_rdst, i_wb_data,
    input  i_aux_valid, i_aux_rdst, i_aux_data,
    output o_aux_ready, o_rf_we, o_rf_rdst, o_rf_data, o_stall_req, o_grant_aux
  );
endinterface

// File: rtl/rf_wport_arbiter.sv
// Shares one register-file write port between WB (priority) and an aux unit.
// Define RFARB_STARVE_EN to add the starvation counter, FORCE state and stall request.
module rf_wport_arbiter #(
  parameter int WIDTH      = 32,
  parameter int STARVE_MAX = 8
) (
  input logic              clk,
  input logic              rst,
  rf_wport_arbiter_if.slave wp
);

  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
    $error("STARVE_MAX must be in 1..15");
  end

`ifdef RFARB_STARVE_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FORCE = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1
  } state_t;
`endif

  state_t           state_q;
  state_t           state_d;
  logic             in_force;
  logic             aux_ready;
  logic             xfer;
  logic             aux_blocked;

  logic             vld_p1;
  logic [4:0]       rdst_p1;
  logic [WIDTH-1:0] data_p1;
  logic             grant_p1;

`ifdef RFARB_STARVE_EN
  localparam logic [3:0] FORCE_AT = 4'(STARVE_MAX - 1);

  logic [3:0] blk_cnt_q;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  assign in_force = (state_q == FORCE);
`else
  assign in_force = 1'b0;
`endif

  // WB owns the port unless the arbiter is forcing an aux grant.
  assign aux_ready      = !wp.i_wb_we || in_force;
  assign xfer           = wp.i_aux_valid && aux_ready;
  assign aux_blocked    = wp.i_aux_valid && !aux_ready;
  assign wp.o_aux_ready = aux_ready;
  assign wp.o_stall_req = in_force;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (aux_blocked) state_d = WAIT;
      end
      WAIT: begin
        if (xfer || !wp.i_aux_valid) begin
          state_d = IDLE;
        end
`ifdef RFARB_STARVE_EN
        // >= rather than == so STARVE_MAX=1 still forces (counter is already 1 in WAIT).
        else if (blk_cnt_q >= FORCE_AT) begin
          state_d = FORCE;
        end
`endif
      end
`ifdef RFARB_STARVE_EN
      FORCE: state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

`ifdef RFARB_STARVE_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blk_cnt_q <= 4'd0;
    end else if (!wp.i_aux_valid || xfer) begin
      blk_cnt_q <= 4'd0;
    end else begin
      blk_cnt_q <= sat_inc4(blk_cnt_q);
    end
  end
`endif

  // ---- stage p1: registered write port; address/data hold when idle ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1   <= 1'b0;
      rdst_p1  <= 5'd0;
      data_p1  <= '0;
      grant_p1 <= 1'b0;
    end else begin
      grant_p1 <= xfer;
      if (xfer) begin
        vld_p1  <= 1'b1;
        rdst_p1 <= wp.i_aux_rdst;
        data_p1 <= wp.i_aux_data;
      end else if (wp.i_wb_we && !in_force) begin
        vld_p1  <= 1'b1;
        rdst_p1 <= wp.i_wb_rdst;
        data_p1 <= wp.i_wb_data;
      end else begin
        vld_p1  <= 1'b0;
      end
    end
  end

  assign wp.o_rf_we     = vld_p1;
  assign wp.o_rf_rdst   = rdst_p1;
  assign wp.o_rf_data   = data_p1;
  assign wp.o_grant_aux = grant_p1;

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed bench for rf_wport_arbiter: vector table plus multi-cycle sequences
// for starvation/forcing (RFARB_STARVE_EN) or plain WB priority (default build).
module tb_rf_wport_arbiter;

  localparam int STARVE = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  rf_wport_arbiter_if #(.WIDTH(32)) bus ();

  rf_wport_arbiter #(.WIDTH(32), .STARVE_MAX(STARVE)) dut (
    .clk (clk),
    .rst (rst),
    .wp  (bus)
  );

  typedef struct {
    logic        wb_we;
    logic [4:0]  wb_rdst;
    logic [31:0] wb_data;
    logic        aux_valid;
    logic [4:0]  aux_rdst;
    logic [31:0] aux_data;
    logic        exp_ready;
    logic        exp_we;
    logic [4:0]  exp_rdst;
    logic [31:0] exp_data;
    logic        exp_grant;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                       input logic av, input logic [4:0] ar, input logic [31:0] ad);
    bus.i_wb_we     = we;
    bus.i_wb_rdst   = wr;
    bus.i_wb_data   = wd;
    bus.i_aux_valid = av;
    bus.i_aux_rdst  = ar;
    bus.i_aux_data  = ad;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic we, input logic [4:0] rd,
                            input logic [31:0] d, input logic g, input logic st);
    chk({tag, ".we"},    bus.o_rf_we,     we);
    chk({tag, ".rdst"},  bus.o_rf_rdst,   rd);
    chk({tag, ".data"},  bus.o_rf_data,   d);
    chk({tag, ".grant"}, bus.o_grant_aux, g);
    chk({tag, ".stall"}, bus.o_stall_req, st);
  endtask

`ifdef RFARB_STARVE_EN
  // From IDLE with WB and aux both requesting: WB writes for STARVE edges, then FORCE.
  task automatic run_to_force(input string tag, input logic [4:0] wr, input logic [31:0] wd);
    for (int k = 1; k <= STARVE; k++) begin
      tick();
      chk($sformatf("%s.stall%0d", tag, k), bus.o_stall_req, (k == STARVE));
      chk($sformatf("%s.we%0d", tag, k),    bus.o_rf_we,     1);
      chk($sformatf("%s.rdst%0d", tag, k),  bus.o_rf_rdst,   wr);
      chk($sformatf("%s.data%0d", tag, k),  bus.o_rf_data,   wd);
    end
    chk({tag, ".force_ready"}, bus.o_aux_ready, 1);
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //            wb_we rdst   wb_data       av    ardst  aux_data      rdy   we    rdst   data          grant
    vecs[0] = '{1'b1, 5'd5,  32'hA5A5A5A5, 1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 5'd5,  32'hA5A5A5A5, 1'b0};
    vecs[1] = '{1'b0, 5'd1,  32'h0BAD0BAD, 1'b1, 5'd7,  32'h12345678, 1'b1, 1'b1, 5'd7,  32'h12345678, 1'b1};
    vecs[2] = '{1'b0, 5'd2,  32'h0000FACE, 1'b0, 5'd8,  32'h0,        1'b1, 1'b0, 5'd7,  32'h12345678, 1'b0};
    vecs[3] = '{1'b1, 5'd3,  32'hDEADBEEF, 1'b1, 5'd3,  32'h11111111, 1'b0, 1'b1, 5'd3,  32'hDEADBEEF, 1'b0};
    vecs[4] = '{1'b0, 5'd4,  32'h44444444, 1'b1, 5'd3,  32'h11111111, 1'b1, 1'b1, 5'd3,  32'h11111111, 1'b1};
    vecs[5] = '{1'b0, 5'd9,  32'h00000BAD, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 5'd3,  32'h11111111, 1'b0};
    vecs[6] = '{1'b1, 5'd0,  32'h00000000, 1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 5'd0,  32'h00000000, 1'b0};
    vecs[7] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 5'd31, 32'hFFFFFFFF, 1'b0};
    vecs[8] = '{1'b0, 5'd6,  32'h66666666, 1'b1, 5'd31, 32'h00000000, 1'b1, 1'b1, 5'd31, 32'h00000000, 1'b1};

    // Reset state and behaviour while reset is held
    drive(0, 0, 0, 0, 0, 0);
    #2;
    check_outs("reset", 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 5'd4, 32'h44);
    #1;
    chk("reset.ready_comb", bus.o_aux_ready, 1);
    tick();
    check_outs("reset.no_xfer", 0, 0, 0, 0, 0);
    drive(1, 5'd4, 32'h55, 1, 5'd4, 32'h44);
    #1;
    chk("reset.ready_wb", bus.o_aux_ready, 0);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b1;

    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].wb_we, vecs[i].wb_rdst, vecs[i].wb_data,
            vecs[i].aux_valid, vecs[i].aux_rdst, vecs[i].aux_data);
      #1;
      chk($sformatf("vec%0d.ready", i), bus.o_aux_ready, vecs[i].exp_ready);
      tick();
      check_outs($sformatf("vec%0d", i), vecs[i].exp_we, vecs[i].exp_rdst,
                 vecs[i].exp_data, vecs[i].exp_grant, 1'b0);
    end

    // Reset pulsed while aux is blocked (WAIT, five blocked cycles)
    drive(1, 5'd6, 32'h66, 1, 5'd10, 32'hAA);
    repeat (5) tick();
    check_outs("pre_rst", 1, 5'd6, 32'h66, 0, 0);
    rst = 1'b0;
    #1;
    check_outs("mid_wait_rst", 0, 0, 0, 0, 0);
    tick();
    check_outs("held_rst", 0, 0, 0, 0, 0);
    rst = 1'b1;
`ifdef RFARB_STARVE_EN
    run_to_force("post_rst", 5'd6, 32'h66);
    tick();
    check_outs("post_rst.aux", 1, 5'd10, 32'hAA, 1, 0);
`else
    drive(0, 5'd6, 32'h66, 1, 5'd10, 32'hAA);
    #1;
    chk("post_rst.ready", bus.o_aux_ready, 1);
    tick();
    check_outs("post_rst.aux", 1, 5'd10, 32'hAA, 1, 0);
`endif
    drive(0, 0, 0, 0, 0, 0);
    tick();

`ifdef RFARB_STARVE_EN
    // Forced grant after STARVE blocked cycles, WB ignored during FORCE
    drive(1, 5'd2, 32'h22, 1, 5'd9, 32'h99);
    run_to_force("force", 5'd2, 32'h22);
    tick();
    check_outs("force.aux", 1, 5'd9, 32'h99, 1, 0);
    drive(1, 5'd2, 32'h22, 0, 0, 0);
    tick();
    check_outs("force.wb_again", 1, 5'd2, 32'h22, 0, 0);

    // Aux drops valid while in FORCE: no write, back to IDLE
    drive(1, 5'd3, 32'h33, 1, 5'd12, 32'hCC);
    run_to_force("drop", 5'd3, 32'h33);
    drive(1, 5'd3, 32'h33, 0, 5'd12, 32'hCC);
    tick();
    check_outs("drop.nowrite", 0, 5'd3, 32'h33, 0, 0);
    chk("drop.idle_ready", bus.o_aux_ready, 0);
    tick();
    check_outs("drop.wb", 1, 5'd3, 32'h33, 0, 0);

    // Reset during FORCE drops stall at once; aux keeps requesting
    drive(1, 5'd4, 32'h44, 1, 5'd13, 32'hDD);
    run_to_force("frst", 5'd4, 32'h44);
    rst = 1'b0;
    #1;
    check_outs("frst.rst", 0, 0, 0, 0, 0);
    tick();
    rst = 1'b1;
    run_to_force("frst.again", 5'd4, 32'h44);
    tick();
    check_outs("frst.aux", 1, 5'd13, 32'hDD, 1, 0);
`else
    // WB held for 20 cycles: aux never granted, never a stall
    drive(1, 5'd2, 32'h22, 1, 5'd9, 32'h99);
    for (int k = 0; k < 20; k++) begin
      #1;
      chk($sformatf("wbhold.ready%0d", k), bus.o_aux_ready, 0);
      tick();
      chk($sformatf("wbhold.stall%0d", k), bus.o_stall_req, 0);
      chk($sformatf("wbhold.grant%0d", k), bus.o_grant_aux, 0);
      chk($sformatf("wbhold.rdst%0d", k),  bus.o_rf_rdst,   5'd2);
    end
    drive(0, 5'd2, 32'h22, 1, 5'd9, 32'h99);
    #1;
    chk("wbhold.release_ready", bus.o_aux_ready, 1);
    tick();
    check_outs("wbhold.aux", 1, 5'd9, 32'h99, 1, 0);
`endif

    drive(0, 0, 0, 0, 0, 0);
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_wport_arbiter.md
RF_WPORT_ARBITER -- requirements
Module: rf_wport_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the data width of the write port.
REQ-002 Parameter STARVE_MAX, default 8, legal 1..15, SHALL set the cycles aux may be blocked before a forced grant.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 i_wb_we  input  1  SHALL be the WB-stage register-write request.
REQ-006 i_wb_rdst  input  5  SHALL be the WB destination register.
REQ-007 i_wb_data  input  WIDTH  SHALL be the WB write data (WB mux output).
REQ-008 i_aux_valid  input  1  SHALL be the aux-requester (multi-cycle unit) write request.
REQ-009 i_aux_rdst  input  5  SHALL be the aux destination register.
REQ-010 i_aux_data  input  WIDTH  SHALL be the aux write data.
REQ-011 o_aux_ready  output  1  SHALL indicate that the aux write is accepted this cycle.
REQ-012 o_rf_we  output  1  SHALL be the register-file write enable.
REQ-013 o_rf_rdst  output  5  SHALL be the register-file write address.
REQ-014 o_rf_data  output  WIDTH  SHALL be the register-file write data.
REQ-015 o_stall_req  output  1  SHALL be the request to stall the pipeline for one cycle.
REQ-016 o_grant_aux  output  1  SHALL be high when o_rf_* carries an aux write.

Function
REQ-017 The block SHALL share one register-file write port between WB (priority) and aux (valid/ready).
REQ-018 o_aux_ready SHALL be combinational: (!i_wb_we) OR (state==FORCE).
REQ-019 An aux transfer SHALL occur only in a cycle with i_aux_valid AND o_aux_ready.
REQ-020 o_rf_we/o_rf_rdst/o_rf_data SHALL be registered, one-cycle latency: they carry the aux write after a transfer, else the WB write if i_wb_we and not FORCE, else o_rf_we=0 with rdst/data holding their previous values.
REQ-021 o_grant_aux SHALL be registered, high exactly in the cycle following an aux transfer.
REQ-022 The FSM SHALL have states IDLE, WAIT, FORCE.
REQ-023 IDLE->WAIT when i_aux_valid AND NOT o_aux_ready; otherwise remain IDLE.
REQ-024 WAIT->IDLE on aux transfer or i_aux_valid low; WAIT->FORCE when still blocked and the blocked counter equals STARVE_MAX-1; otherwise remain WAIT.
REQ-025 FORCE->IDLE unconditionally after one cycle.
REQ-026 o_stall_req SHALL be high exactly while state==FORCE (Moore output).
REQ-027 In FORCE, i_wb_* SHALL be ignored (pipeline is stalled and re-presents the WB write next cycle).
REQ-028 If i_aux_valid is low in FORCE, no write SHALL occur (o_rf_we=0 next cycle) and the FSM SHALL still return to IDLE.
REQ-029 The 4-bit blocked counter SHALL increment each cycle aux is valid but not ready, saturate at 15, and clear on transfer or when i_aux_valid is low.
REQ-030 A same-cycle WB write and aux request to the same rdst SHALL be serialised WB first; no merging.

Reset
REQ-031 On rst low, asynchronously: state=IDLE, counter=0, o_rf_we=0, o_rf_rdst=0, o_rf_data=0, o_grant_aux=0, o_stall_req=0.
REQ-032 o_aux_ready SHALL follow REQ-018 combinationally during reset, but no transfer SHALL be registered while rst is low.
REQ-033 Reset asserted mid-FORCE SHALL drop o_stall_req immediately; the aux request is not lost (aux retains valid).

Configuration
REQ-034 Macro RFARB_STARVE_EN, when defined, SHALL compile in the counter, the FORCE state and o_stall_req behaviour.
REQ-035 Without RFARB_STARVE_EN, aux SHALL be granted only in cycles with i_wb_we low, o_stall_req SHALL be tied 0, and the FSM SHALL use only IDLE and WAIT.

Verification
REQ-036 i_wb_we=1, rdst=5, data=0xA5A5A5A5, aux idle -> next cycle o_rf_we=1, rdst=5, data=0xA5A5A5A5, o_grant_aux=0.
REQ-037 i_wb_we=0, aux valid rdst=7 data=0x12345678 -> o_aux_ready=1 same cycle; next cycle o_rf_we=1, rdst=7, o_grant_aux=1.
REQ-038 STARVE_MAX=8, i_wb_we held 1, aux valid -> o_stall_req high for exactly 1 cycle after 8 blocked cycles, aux write issued next cycle.
REQ-039 Forced grant with i_aux_valid dropped in FORCE -> o_stall_req pulses, o_rf_we=0 next cycle, FSM back to IDLE.
REQ-040 rst pulsed low in WAIT with counter=5 -> all outputs 0 immediately, counter restarts at 0 after release.
REQ-041 RFARB_STARVE_EN undefined, i_wb_we held 1 for 20 cycles -> o_stall_req never high, aux granted first cycle i_wb_we=0.
